// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  // Stores only have signed-less B/H/W encodings; loads add the unsigned variants.
  function automatic logic funct3_ok(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extracts/extends a load lane and merges a store lane into a word.
// Offsets are masked to the access size (halfword uses offset[1], word ignores the offset).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = word[{offset[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns RV32I loads/stores into word accesses, sub-word stores by read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of masking the offset.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 16384,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  lsu_state_t  state;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] wdata_q;
  logic [1:0]  offset_q;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        misaligned;
  logic        req_err;

  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_err = (req_addr >= MEM_LIMIT) || !funct3_ok(req_store, req_funct3) || misaligned;
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (offset_q),
    .word       (mem_data_out),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Every memory-facing signal is a flop so address/data never glitch while mem_we is high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= RESET_ADDR;
      mem_data_in <= 32'h0;
      funct3_q    <= F3_B;
      store_q     <= 1'b0;
      wdata_q     <= 32'h0;
      offset_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            store_q     <= req_store;
            wdata_q     <= req_wdata;
            offset_q    <= req_addr[1:0];
            mem_address <= {req_addr[31:2], 2'b00};
            req_ready   <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_err    <= req_err;
            if (req_err) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_store && (req_funct3 == F3_W)) begin
              mem_data_in <= req_wdata;
              mem_we      <= 1'b1;
              state       <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (store_q) begin
            mem_data_in <= store_word;
            mem_we      <= 1'b1;
            state       <= WRITE;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
